// File: rtl/yoda_rle_decoder_if.sv
// Word-stream handshake bundle for the YODA run-length decoder:
// compressed input (valid/ready) and decoded output (valid/ready).
interface yoda_rle_decoder_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // slave: the decoder itself; master: the source/sink environment.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/yoda_rle_decoder.sv
// Parametrised run-length decoder: header of HDR_WORDS words (pair count, MSW first),
// then (count, value) pairs; each value is emitted count times, then finish is raised.
module yoda_rle_decoder #(
  parameter int DATA_W    = 8,
  parameter int HDR_WORDS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  yoda_rle_decoder_if.slave        bus,
  output logic                     busy,
  output logic                     finish
);
  localparam int PC_W   = HDR_WORDS * DATA_W;
  localparam int HIDX_W = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
  localparam logic [HIDX_W-1:0] HDR_LAST = HIDX_W'(HDR_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_CNT, S_VAL, S_EMIT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [HIDX_W-1:0]   hdr_idx_q, hdr_idx_d;
  logic [PC_W-1:0]     pair_cnt_q, pair_cnt_d;
  logic [DATA_W-1:0]   run_cnt_q, run_cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic                in_xfer, out_xfer;
  logic [PC_W-1:0]     pair_shift, pair_dec;

  // Handshake outputs are decoded from the state register only, so there is
  // no combinational path from out_ready/in_valid back to either valid or ready.
  assign bus.in_ready  = (state_q == S_HDR) || (state_q == S_CNT) || (state_q == S_VAL);
  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign finish        = (state_q == S_DONE);

  assign in_xfer    = bus.in_valid && bus.in_ready;
  assign out_xfer   = bus.out_valid && bus.out_ready;
  assign pair_shift = (pair_cnt_q << DATA_W) | PC_W'(bus.in_data);
  assign pair_dec   = pair_cnt_q - PC_W'(1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    pair_cnt_d = pair_cnt_q;
    run_cnt_d  = run_cnt_q;
    out_data_d = out_data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_HDR;
          hdr_idx_d  = '0;
          pair_cnt_d = '0;
        end
      end
      S_HDR: begin
        if (in_xfer) begin
          pair_cnt_d = pair_shift;
          if (hdr_idx_q == HDR_LAST) begin
            hdr_idx_d = '0;
            state_d   = (pair_shift == '0) ? S_DONE : S_CNT;
          end else begin
            hdr_idx_d = hdr_idx_q + HIDX_W'(1);
          end
        end
      end
      S_CNT: begin
        if (in_xfer) begin
          run_cnt_d = bus.in_data;
          state_d   = S_VAL;
        end
      end
      S_VAL: begin
        // CNT is only entered with pair_cnt non-zero, so this never wraps.
        if (in_xfer) begin
          out_data_d = bus.in_data;
          pair_cnt_d = pair_dec;
          if (run_cnt_q != '0)     state_d = S_EMIT;
          else if (pair_dec != '0) state_d = S_CNT;
          else                     state_d = S_DONE;
        end
      end
      S_EMIT: begin
        if (out_xfer) begin
          run_cnt_d = run_cnt_q - DATA_W'(1);
          if (run_cnt_q == DATA_W'(1))
            state_d = (pair_cnt_q != '0) ? S_CNT : S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hdr_idx_q  <= '0;
      pair_cnt_q <= '0;
      run_cnt_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      pair_cnt_q <= pair_cnt_d;
      run_cnt_q  <= run_cnt_d;
      out_data_q <= out_data_d;
    end
  end
endmodule

// File: tb/tb_yoda_rle_decoder.sv
// Directed bench for yoda_rle_decoder: an 8-bit/2-word-header instance and a
// 16-bit/1-word-header instance, with queue scoreboards fed at stimulus time.
module tb_yoda_rle_decoder;
  logic clk = 1'b0;
  logic rst_n;
  logic start8, start16;
  logic busy8, finish8, busy16, finish16;

  int checks = 0;
  int errors = 0;

  logic [7:0]  q8[$];
  logic [15:0] q16[$];

  bit         bp_mode = 1'b0;
  int         bp_idx  = 0;
  logic [3:0] bp_pat  = 4'b1001;

  logic       stalled8 = 1'b0;
  logic [7:0] held8;

  yoda_rle_decoder_if #(.DATA_W(8))  if8 ();
  yoda_rle_decoder_if #(.DATA_W(16)) if16 ();

  yoda_rle_decoder #(.DATA_W(8), .HDR_WORDS(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bus(if8), .busy(busy8), .finish(finish8)
  );
  yoda_rle_decoder #(.DATA_W(16), .HDR_WORDS(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .bus(if16), .busy(busy16), .finish(finish16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sink backpressure: out_ready follows 1,0,0,1,... when bp_mode is set.
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      if8.out_ready = bp_pat[bp_idx];
      bp_idx = (bp_idx + 1) % 4;
    end else begin
      if8.out_ready = 1'b1;
    end
  end

  // Output monitors: sampled at negedge, a word with valid&&ready transfers on the next posedge.
  always @(negedge clk) begin
    if (if8.out_valid === 1'b1) begin
      check("in_ready_low_in_emit", {31'd0, if8.in_ready}, 32'd0);
      if (stalled8) check("out8_stable", {24'd0, if8.out_data}, {24'd0, held8});
      if (if8.out_ready === 1'b1) begin
        logic [7:0] exp;
        exp = 8'hxx;
        if (q8.size() > 0) exp = q8.pop_front();
        check("out8_data", {24'd0, if8.out_data}, {24'd0, exp});
        stalled8 = 1'b0;
      end else begin
        stalled8 = 1'b1;
        held8    = if8.out_data;
      end
    end else begin
      stalled8 = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (if16.out_valid === 1'b1 && if16.out_ready === 1'b1) begin
      logic [15:0] exp;
      exp = 16'hxxxx;
      if (q16.size() > 0) exp = q16.pop_front();
      check("out16_data", {16'd0, if16.out_data}, {16'd0, exp});
    end
  end

  task automatic send8(input logic [7:0] w);
    bit got = 1'b0;
    if8.in_data  = w;
    if8.in_valid = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = (if8.in_ready === 1'b1);
    end
    check("send8_accepted", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1 if8.in_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] w);
    bit got = 1'b0;
    if16.in_data  = w;
    if16.in_valid = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = (if16.in_ready === 1'b1);
    end
    check("send16_accepted", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1 if16.in_valid = 1'b0;
  endtask

  task automatic pulse_start8();
    @(posedge clk); #1 start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
  endtask

  task automatic pulse_start16();
    @(posedge clk); #1 start16 = 1'b1;
    @(posedge clk); #1 start16 = 1'b0;
  endtask

  task automatic wait_done8(input string tag, input int budget);
    for (int i = 0; i < budget && finish8 !== 1'b1; i++) @(negedge clk);
    check({tag, "_finish"}, {31'd0, finish8}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy8}, 32'd0);
    check({tag, "_drained"}, q8.size(), 32'd0);
  endtask

  task automatic wait_done16(input string tag, input int budget);
    for (int i = 0; i < budget && finish16 !== 1'b1; i++) @(negedge clk);
    check({tag, "_finish"}, {31'd0, finish16}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy16}, 32'd0);
    check({tag, "_drained"}, q16.size(), 32'd0);
  endtask

  task automatic t2_stream();
    q8.push_back(8'hAA); q8.push_back(8'hAA); q8.push_back(8'hAA); q8.push_back(8'h55);
    pulse_start8();
    send8(8'h00); send8(8'h02); send8(8'h03); send8(8'hAA); send8(8'h01); send8(8'h55);
  endtask

  task automatic t6_stream();
    for (int i = 0; i < 256; i++) q16.push_back(16'hBEEF);
    send16(16'h0001); send16(16'h0100); send16(16'hBEEF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; start16 = 1'b0;
    if8.in_data = '0;  if8.in_valid = 1'b0;  if8.out_ready = 1'b1;
    if16.in_data = '0; if16.in_valid = 1'b0; if16.out_ready = 1'b1;

    // T1: reset values, async assertion mid-cycle, start ignored during reset
    #12;
    check("rst_in_ready", {31'd0, if8.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, if8.out_valid}, 32'd0);
    check("rst_out_data", {24'd0, if8.out_data}, 32'd0);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_finish", {31'd0, finish8}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    pulse_start8();
    check("t1_busy_after_start", {31'd0, busy8}, 32'd1);
    @(posedge clk); #3 rst_n = 1'b0; start8 = 1'b1;
    #1;
    check("t1_async_busy", {31'd0, busy8}, 32'd0);
    check("t1_async_in_ready", {31'd0, if8.in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 start8 = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    check("t1_idle_after_release", {31'd0, busy8}, 32'd0);

    // T2: basic stream
    t2_stream();
    wait_done8("t2", 100);

    // T3: same stream under sink backpressure
    bp_idx = 0; bp_mode = 1'b1;
    t2_stream();
    wait_done8("t3", 200);
    bp_mode = 1'b0;

    // T4: zero-pair header, then an empty run followed by a real one
    pulse_start8();
    send8(8'h00); send8(8'h00);
    wait_done8("t4_zero_hdr", 20);
    q8.push_back(8'h22); q8.push_back(8'h22);
    pulse_start8();
    send8(8'h00); send8(8'h02); send8(8'h00); send8(8'h11); send8(8'h02); send8(8'h22);
    wait_done8("t4_empty_run", 100);

    // T5: reset after the first of three words, then a clean rerun
    q8.push_back(8'hAA);
    pulse_start8();
    send8(8'h00); send8(8'h01); send8(8'h03); send8(8'hAA);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("t5_out_valid", {31'd0, if8.out_valid}, 32'd0);
    check("t5_finish", {31'd0, finish8}, 32'd0);
    check("t5_one_word_out", q8.size(), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    t2_stream();
    wait_done8("t5_rerun", 100);

    // T6: 16-bit words, single header word, 256-word run, rerun from DONE
    pulse_start16();
    t6_stream();
    wait_done16("t6", 400);
    pulse_start16();
    check("t6_restart_finish_clear", {31'd0, finish16}, 32'd0);
    check("t6_restart_busy", {31'd0, busy16}, 32'd1);
    t6_stream();
    wait_done16("t6_rerun", 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
